// File: rtl/alu_decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and execute.
// The decode stage takes the slave modport; the fetch/execute side takes master.
interface alu_decode_stage_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_op;
    logic [5:0]  shamt;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  dest_idx;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_unsigned;
    logic        jump;
    logic        link;
    logic        jump_reg;
    logic        illegal;
    logic [2:0]  br_cond;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, alu_op, shamt, rs_idx, rt_idx, dest_idx, imm, use_imm,
               reg_write, mem_read, mem_write, mem_byte, mem_unsigned, jump, link, jump_reg,
               illegal, br_cond
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, alu_op, shamt, rs_idx, rt_idx, dest_idx, imm, use_imm,
               reg_write, mem_read, mem_write, mem_byte, mem_unsigned, jump, link, jump_reg,
               illegal, br_cond
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Single-entry registered MIPS decode stage with valid/ready on both sides.
// Flush drops the held and incoming instruction; reset clears every output.
module alu_decode_stage (
    input logic               clk,
    input logic               reset,
    alu_decode_stage_if.slave bus
);
    typedef struct packed {
        logic [5:0]  alu_op;
        logic [5:0]  shamt;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  dest_idx;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_byte;
        logic        mem_unsigned;
        logic        jump;
        logic        link;
        logic        jump_reg;
        logic        illegal;
        logic [2:0]  br_cond;
    } bundle_t;

    bundle_t     dec;
    bundle_t     bundle_q;
    logic        valid_q;
    logic        legal;
    logic        accept;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [31:0] bimm;

    assign op    = bus.in_instr[31:26];
    assign rs    = bus.in_instr[25:21];
    assign rt    = bus.in_instr[20:16];
    assign rd    = bus.in_instr[15:11];
    assign funct = bus.in_instr[5:0];
    assign simm  = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    assign zimm  = {16'h0000, bus.in_instr[15:0]};
    assign bimm  = {simm[29:0], 2'b00};

    always_comb begin
        dec          = '0;
        legal        = 1'b1;
        dec.shamt    = {1'b0, bus.in_instr[10:6]};
        dec.rs_idx   = rs;
        dec.rt_idx   = rt;
        case (op)
            6'h00: begin
                dec.dest_idx  = rd;
                dec.reg_write = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.alu_op = 6'd0;
                    6'h22, 6'h23: dec.alu_op = 6'd1;
                    6'h24:        dec.alu_op = 6'd7;
                    6'h25:        dec.alu_op = 6'd8;
                    6'h26:        dec.alu_op = 6'd9;
                    6'h27:        dec.alu_op = 6'd10;
                    6'h2A, 6'h2B: dec.alu_op = 6'd6;
                    6'h00:        dec.alu_op = 6'd4;
                    6'h02:        dec.alu_op = 6'd5;
                    6'h03:        dec.alu_op = 6'd11;
                    6'h1A: begin
                        dec.alu_op    = 6'd3;
                        dec.reg_write = 1'b0;
                    end
                    6'h08: begin
                        dec.jump      = 1'b1;
                        dec.jump_reg  = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h1C: begin
                if (funct == 6'h02) begin
                    dec.alu_op    = 6'd2;
                    dec.dest_idx  = rd;
                    dec.reg_write = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0F: begin
                dec.use_imm   = 1'b1;
                dec.dest_idx  = rt;
                dec.reg_write = 1'b1;
                // ori and lui (op[2] set) take the zero-extended immediate
                dec.imm       = op[2] ? zimm : simm;
                case (op)
                    6'h09:   dec.alu_op = 6'd0;
                    6'h0D:   dec.alu_op = 6'd8;
                    6'h0F:   dec.alu_op = 6'd12;
                    default: dec.alu_op = 6'd6;
                endcase
            end
            6'h20, 6'h23, 6'h24: begin
                dec.use_imm      = 1'b1;
                dec.imm          = simm;
                dec.mem_read     = 1'b1;
                dec.reg_write    = 1'b1;
                dec.dest_idx     = rt;
                dec.mem_byte     = (op != 6'h23);
                dec.mem_unsigned = (op == 6'h24);
            end
            6'h28, 6'h2B: begin
                dec.use_imm   = 1'b1;
                dec.imm       = simm;
                dec.mem_write = 1'b1;
                dec.mem_byte  = (op == 6'h28);
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec.alu_op  = 6'd1;
                dec.imm     = bimm;
                dec.br_cond = op[2:0] - 3'd3;
            end
            6'h01: begin
                dec.alu_op = 6'd1;
                dec.imm    = bimm;
                if (rt == 5'd0)      dec.br_cond = 3'd5;
                else if (rt == 5'd1) dec.br_cond = 3'd6;
                else                 legal = 1'b0;
            end
            6'h02, 6'h03: begin
                dec.jump = 1'b1;
                dec.imm  = {4'b0000, bus.in_instr[25:0], 2'b00};
                if (op[0]) begin
                    dec.link      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest_idx  = 5'd31;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.shamt   = {1'b0, bus.in_instr[10:6]};
            dec.rs_idx  = rs;
            dec.rt_idx  = rt;
            dec.illegal = 1'b1;
        end
        // Writes to $zero are suppressed so the all-zero word is a true nop
        if (dec.dest_idx == 5'd0) dec.reg_write = 1'b0;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.alu_op       = bundle_q.alu_op;
    assign bus.shamt        = bundle_q.shamt;
    assign bus.rs_idx       = bundle_q.rs_idx;
    assign bus.rt_idx       = bundle_q.rt_idx;
    assign bus.dest_idx     = bundle_q.dest_idx;
    assign bus.imm          = bundle_q.imm;
    assign bus.use_imm      = bundle_q.use_imm;
    assign bus.reg_write    = bundle_q.reg_write;
    assign bus.mem_read     = bundle_q.mem_read;
    assign bus.mem_write    = bundle_q.mem_write;
    assign bus.mem_byte     = bundle_q.mem_byte;
    assign bus.mem_unsigned = bundle_q.mem_unsigned;
    assign bus.jump         = bundle_q.jump;
    assign bus.link         = bundle_q.link;
    assign bus.jump_reg     = bundle_q.jump_reg;
    assign bus.illegal      = bundle_q.illegal;
    assign bus.br_cond      = bundle_q.br_cond;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed cases plus random traffic against a
// mnemonic-level decode model and a one-entry handshake model.
module tb_alu_decode_stage;
    typedef struct packed {
        logic [5:0]  alu_op;
        logic [5:0]  shamt;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  dest_idx;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_byte;
        logic        mem_unsigned;
        logic        jump;
        logic        link;
        logic        jump_reg;
        logic        illegal;
        logic [2:0]  br_cond;
    } bundle_t;

    typedef enum int {
        MIll, MAdd, MSub, MMul, MDiv, MSll, MSrl, MSra, MSlt, MAnd, MOr, MXor, MNor, MJr,
        MAddiu, MSlti, MOri, MLui, MLw, MLb, MLbu, MSw, MSb,
        MBeq, MBne, MBlez, MBgtz, MBltz, MBgez, MJ, MJal
    } mn_e;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_decode_stage_if bus();

    alu_decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bundle_t dut_b;
    assign dut_b = {bus.alu_op, bus.shamt, bus.rs_idx, bus.rt_idx, bus.dest_idx, bus.imm,
                    bus.use_imm, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_byte,
                    bus.mem_unsigned, bus.jump, bus.link, bus.jump_reg, bus.illegal,
                    bus.br_cond};

    int n_checks = 0;
    int n_pass   = 0;

    bit      m_valid = 1'b0;
    bit      m_zero  = 1'b0;
    bundle_t m_b     = '0;

    logic [5:0] r_functs [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h1A, 6'h08};
    logic [5:0] i_ops [17] = '{6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0F, 6'h23, 6'h20, 6'h24,
                               6'h2B, 6'h28, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h1C};

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic mn_e classify(logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20, 6'h21: return MAdd;
                    6'h22, 6'h23: return MSub;
                    6'h24: return MAnd;
                    6'h25: return MOr;
                    6'h26: return MXor;
                    6'h27: return MNor;
                    6'h2A, 6'h2B: return MSlt;
                    6'h00: return MSll;
                    6'h02: return MSrl;
                    6'h03: return MSra;
                    6'h1A: return MDiv;
                    6'h08: return MJr;
                    default: return MIll;
                endcase
            end
            6'h1C: return (w[5:0] == 6'h02) ? MMul : MIll;
            6'h09: return MAddiu;
            6'h0A, 6'h0B: return MSlti;
            6'h0D: return MOri;
            6'h0F: return MLui;
            6'h23: return MLw;
            6'h20: return MLb;
            6'h24: return MLbu;
            6'h2B: return MSw;
            6'h28: return MSb;
            6'h04: return MBeq;
            6'h05: return MBne;
            6'h06: return MBlez;
            6'h07: return MBgtz;
            6'h01: return (w[20:16] == 5'd0) ? MBltz : (w[20:16] == 5'd1) ? MBgez : MIll;
            6'h02: return MJ;
            6'h03: return MJal;
            default: return MIll;
        endcase
    endfunction

    function automatic bundle_t model(logic [31:0] w);
        bundle_t     e;
        mn_e         m;
        logic [31:0] sx;
        logic [31:0] zx;
        m  = classify(w);
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'h0, w[15:0]};
        e  = '0;
        e.shamt  = {1'b0, w[10:6]};
        e.rs_idx = w[25:21];
        e.rt_idx = w[20:16];
        case (m)
            MSub, MBeq, MBne, MBlez, MBgtz, MBltz, MBgez: e.alu_op = 6'd1;
            MMul: e.alu_op = 6'd2;
            MDiv: e.alu_op = 6'd3;
            MSll: e.alu_op = 6'd4;
            MSrl: e.alu_op = 6'd5;
            MSlt, MSlti: e.alu_op = 6'd6;
            MAnd: e.alu_op = 6'd7;
            MOr, MOri: e.alu_op = 6'd8;
            MXor: e.alu_op = 6'd9;
            MNor: e.alu_op = 6'd10;
            MSra: e.alu_op = 6'd11;
            MLui: e.alu_op = 6'd12;
            default: e.alu_op = 6'd0;
        endcase
        if (m inside {MAdd, MSub, MMul, MDiv, MSll, MSrl, MSra, MSlt, MAnd, MOr, MXor, MNor,
                      MJr})
            e.dest_idx = w[15:11];
        if (m inside {MAddiu, MSlti, MOri, MLui, MLw, MLb, MLbu}) e.dest_idx = w[20:16];
        if (m == MJal) e.dest_idx = 5'd31;
        e.use_imm = m inside {MAddiu, MSlti, MOri, MLui, MLw, MLb, MLbu, MSw, MSb};
        if (e.use_imm) e.imm = (m == MOri || m == MLui) ? zx : sx;
        case (m)
            MBeq:  e.br_cond = 3'd1;
            MBne:  e.br_cond = 3'd2;
            MBlez: e.br_cond = 3'd3;
            MBgtz: e.br_cond = 3'd4;
            MBltz: e.br_cond = 3'd5;
            MBgez: e.br_cond = 3'd6;
            default: e.br_cond = 3'd0;
        endcase
        if (e.br_cond != 3'd0) e.imm = sx * 4;
        if (m == MJ || m == MJal) begin
            e.jump = 1'b1;
            e.imm  = {6'b0, w[25:0]} * 4;
        end
        e.link         = (m == MJal);
        e.jump         = e.jump || (m == MJr);
        e.jump_reg     = (m == MJr);
        e.mem_read     = m inside {MLw, MLb, MLbu};
        e.mem_write    = m inside {MSw, MSb};
        e.mem_byte     = m inside {MLb, MLbu, MSb};
        e.mem_unsigned = (m == MLbu);
        e.illegal      = (m == MIll);
        e.reg_write    = !(m inside {MIll, MDiv, MJr, MSw, MSb, MBeq, MBne, MBlez, MBgtz,
                                     MBltz, MBgez, MJ}) && (e.dest_idx != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = r_functs[$urandom_range(0, 14)];
        end else if (k < 8) begin
            w[31:26] = i_ops[$urandom_range(0, 16)];
            if (w[31:26] == 6'h1C && $urandom_range(0, 1) == 1) w[5:0] = 6'h02;
        end else if (k == 8) begin
            w[31:26] = 6'h01;
            if ($urandom_range(0, 3) != 0) w[20:17] = 4'h0;
        end
        if ($urandom_range(0, 7) == 0) w[20:11] = 10'h000;
        return w;
    endfunction

    // One clock: check in_ready, advance the reference, then check outputs
    task automatic step();
        bit acc;
        #1;
        check("in_ready", 128'(bus.in_ready), 128'(!m_valid || bus.out_ready));
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_b     = '0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_zero  = 1'b0;
            m_b     = model(bus.in_instr);
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 128'(bus.out_valid), 128'(m_valid));
        if (m_valid || m_zero) check("bundle", 128'(dut_b), 128'(m_b));
    endtask

    task automatic drive(logic v, logic [31:0] i, logic r, logic f);
        bus.in_valid  = v;
        bus.in_instr  = i;
        bus.out_ready = r;
        bus.flush     = f;
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h012A4020, 1'b1, 1'b0);
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_bundle", 128'(dut_b), 128'(0));
        reset = 1'b0;

        drive(1'b1, 32'h012A4020, 1'b1, 1'b0);
        check("add_alu", 128'(bus.alu_op), 128'(0));
        check("add_rs", 128'(bus.rs_idx), 128'(9));
        check("add_rt", 128'(bus.rt_idx), 128'(10));
        check("add_dest", 128'(bus.dest_idx), 128'(8));
        check("add_rw", 128'(bus.reg_write), 128'(1));
        check("add_use_imm", 128'(bus.use_imm), 128'(0));

        drive(1'b1, 32'h3C01ABCD, 1'b1, 1'b0);
        check("lui_alu", 128'(bus.alu_op), 128'(12));
        check("lui_imm", 128'(bus.imm), 128'(32'h0000ABCD));
        drive(1'b1, 32'h8C220004, 1'b1, 1'b0);
        check("lw_alu", 128'(bus.alu_op), 128'(0));
        check("lw_imm", 128'(bus.imm), 128'(4));
        check("lw_mem_read", 128'(bus.mem_read), 128'(1));
        check("lw_dest", 128'(bus.dest_idx), 128'(2));

        drive(1'b1, 32'h00031080, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1000FFFF, 1'b0, 1'b0);
            check("stall_ready", 128'(bus.in_ready), 128'(0));
            check("sll_shamt", 128'(bus.shamt), 128'(2));
            check("sll_alu", 128'(bus.alu_op), 128'(4));
        end
        drive(1'b1, 32'h1000FFFF, 1'b1, 1'b0);
        check("beq_cond", 128'(bus.br_cond), 128'(1));
        check("beq_alu", 128'(bus.alu_op), 128'(1));
        check("beq_imm", 128'(bus.imm), 128'(32'hFFFFFFFC));

        drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
        check("ill_flag", 128'(bus.illegal), 128'(1));
        check("ill_ctl", 128'({bus.reg_write, bus.mem_read, bus.mem_write, bus.jump, bus.link,
                               bus.br_cond, bus.alu_op}), 128'(0));
        check("ill_valid", 128'(bus.out_valid), 128'(1));

        drive(1'b1, 32'h012A4020, 1'b0, 1'b0);
        drive(1'b1, 32'h8C220004, 1'b0, 1'b1);
        check("flush_valid", 128'(bus.out_valid), 128'(0));

        drive(1'b1, 32'h012A4020, 1'b1, 1'b0);
        drive(1'b1, 32'h8C220004, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 32'h8C220004, 1'b0, 1'b0);
        check("rst_stall_valid", 128'(bus.out_valid), 128'(0));
        check("rst_stall_bundle", 128'(dut_b), 128'(0));
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("post_rst_ready", 128'(bus.in_ready), 128'(1));

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  fetch stage presents an instruction; in_instr  in  32  MIPS instruction word; in_ready  out  1  block accepts in_instr this cycle.
REQ-004 flush  in  1  discard the held and incoming instruction (taken branch/jump).
REQ-005 out_valid  out  1  decoded bundle valid; out_ready  in  1  execute stage consumes bundle this cycle.
REQ-006 alu_op  out  6  ALU operation code: 0 add, 1 sub, 2 mul, 3 div, 4 sll, 5 srl, 6 slt, 7 and, 8 or, 9 xor, 10 nor, 11 sra, 12 load-upper.
REQ-007 shamt  out  6  shift amount, {1'b0, instr[10:6]}; rs_idx, rt_idx, dest_idx  out  5 each.
REQ-008 imm  out  32  extended immediate; use_imm  out  1  ALU operand 2 = imm instead of rt.
REQ-009 reg_write, mem_read, mem_write, mem_byte, mem_unsigned, jump, link, jump_reg, illegal  out  1 each; br_cond  out  3  (0 none, 1 eq, 2 ne, 3 lez, 4 gtz, 5 ltz, 6 gez).

Function
REQ-010 The block SHALL be a single registered decode stage: one bundle held, latency exactly 1 cycle from acceptance to out_valid.
REQ-011 in_ready SHALL equal (!out_valid || out_ready) combinationally; acceptance = in_valid && in_ready.
REQ-012 On acceptance without flush, all outputs SHALL load the decode of in_instr and out_valid SHALL be 1 next cycle.
REQ-013 Bundle consumed (out_valid && out_ready) with no acceptance SHALL clear out_valid; consume and accept in same cycle SHALL replace the bundle with no bubble.
REQ-014 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-015 flush SHALL take priority: out_valid=0 next cycle, incoming instruction dropped regardless of in_valid.
REQ-016 R-type (op 0x00) funct: 20/21 add->0, 22/23 sub->1, 24 and->7, 25 or->8, 26 xor->9, 27 nor->10, 2A/2B slt->6, 00 sll->4, 02 srl->5, 03 sra->11, 1A div->3 (reg_write 0), 08 jr: jump=1, jump_reg=1, reg_write 0; dest_idx=rd.
REQ-017 op 0x1C funct 0x02 (mul) SHALL decode alu_op 2, dest rd, reg_write 1.
REQ-018 I-type: addiu 09->0, slti/sltiu 0A/0B->6 (sign-extended imm), ori 0D->8 (zero-extended), lui 0F->12; use_imm 1, dest_idx=rt.
REQ-019 Loads lw 23, lb 20, lbu 24: alu_op 0, use_imm 1, sign-extended imm, mem_read 1, reg_write 1, dest rt; mem_byte 1 for lb/lbu; mem_unsigned 1 for lbu only.
REQ-020 Stores sw 2B, sb 28: alu_op 0, use_imm 1, mem_write 1, reg_write 0; mem_byte 1 for sb.
REQ-021 Branches beq 04 (br_cond 1), bne 05 (2), blez 06 (3), bgtz 07 (4), REGIMM 01 rt=0 (5), rt=1 (6): alu_op 1, use_imm 0, imm = sign-extended offset << 2, reg_write 0.
REQ-022 j 02: jump 1, imm = {4'b0, instr[25:0], 2'b00}; jal 03: same plus link 1, reg_write 1, dest_idx 31.
REQ-023 reg_write SHALL be forced 0 when dest_idx is 0 (so 0x00000000 is a nop).
REQ-024 Any other encoding SHALL decode illegal=1, alu_op 0, and all of reg_write, mem_read, mem_write, jump, link, br_cond zero; out_valid still asserted.

Reset
REQ-025 While reset is sampled high, next-cycle state SHALL be out_valid 0 and all other outputs 0; reset overrides flush and acceptance.
REQ-026 Reset asserted mid-stall SHALL drop the held bundle; in_ready SHALL be 1 the cycle after reset deasserts.

Verification
REQ-027 in 0x012A4020 (add t0,t1,t2) -> next cycle out_valid 1, alu_op 0, rs 9, rt 10, dest 8, reg_write 1, use_imm 0.
REQ-028 in 0x3C01ABCD (lui at) then 0x8C220004 (lw v0,4(at)) back-to-back, out_ready 1 -> alu_op 12 imm 0x0000ABCD, then alu_op 0 imm 4 mem_read 1 dest 2.
REQ-029 Hold out_ready 0 for 3 cycles after 0x00031080 (sll v0,v1,2) -> in_ready 0, outputs stable, shamt 2; release -> next instruction accepted same cycle.
REQ-030 in 0x1000FFFF (beq) -> br_cond 1, alu_op 1, imm 0xFFFFFFFC; in 0xFC000000 -> illegal 1, all write/control flags 0.
REQ-031 flush asserted with in_valid 1 while bundle held -> out_valid 0 next cycle; reset during stall -> out_valid 0, all outputs 0.
